liteeth_sram_fifo_ctrl: RTL and testbench

- Initiator-side controller that drives one 1rw1r SRAM macro (64 bits wide, 64 words deep) as a synchronous FIFO for the LiteEth datapath.
- Writes go through the rw0 port and reads through the r0 port.
- Presents a valid/ready sink and a valid/ready source to the MAC buffering logic.
- Hides the SRAM's one-cycle read latency with a 2-entry output buffer, sustaining one word per cycle in and out.

---
 rtl/liteeth_sram_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_liteeth_sram_fifo_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/liteeth_sram_fifo_ctrl.sv
// LiteEth SRAM FIFO controller.
// Drives a 1rw1r SRAM macro as a synchronous FIFO: rw0 is used for writes and r0 for reads.
// A 2-entry output buffer hides the one-cycle SRAM read latency, so the FIFO can move
// one word per cycle in and one word per cycle out.
module liteeth_sram_fifo_ctrl #(
    parameter int BITS       = 64,
    parameter int WORD_DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic [BITS-1:0]       sink_data,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic [BITS-1:0]       source_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  sram_rw0_ce,
    output logic                  sram_rw0_we,
    output logic [ADDR_WIDTH-1:0] sram_rw0_addr,
    output logic [BITS-1:0]       sram_rw0_wd,
    output logic                  sram_r0_ce,
    output logic [ADDR_WIDTH-1:0] sram_r0_addr,
    input  logic [BITS-1:0]       sram_r0_rd
);

    localparam int                CW      = ADDR_WIDTH + 1;
    localparam int                LW      = ADDR_WIDTH + 2;
    localparam logic [CW-1:0]     DEPTH_C = CW'(WORD_DEPTH);
    localparam logic [LW-1:0]     DEPTH_L = LW'(WORD_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         mem_count_q, mem_count_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            out_count_q, out_count_d;
    logic [BITS-1:0]       out0_q, out0_d;
    logic [BITS-1:0]       out1_q, out1_d;

    logic                  wr_fire;
    logic                  rd_issue;
    logic                  pop;
    logic [2:0]            pending;
    logic [LW-1:0]         total;

    // Handshakes, SRAM port drive and level reporting; everything is gated while reset is held.
    always_comb begin
        source_valid  = (out_count_q != 2'd0);
        source_data   = out0_q;
        pop           = source_valid && source_ready;
        sink_ready    = rst_n && (mem_count_q < DEPTH_C) && !flush;
        wr_fire       = sink_valid && sink_ready;
        pending       = {1'b0, out_count_q} + {2'b00, inflight_q};
        rd_issue      = rst_n && (mem_count_q != '0) && !flush
                        && (pending < (3'd2 + {2'b00, pop}));
        sram_rw0_ce   = wr_fire;
        sram_rw0_we   = wr_fire;
        sram_rw0_addr = wr_ptr_q;
        sram_rw0_wd   = sink_data;
        sram_r0_ce    = rd_issue;
        sram_r0_addr  = rd_ptr_q;
        total         = {1'b0, mem_count_q} + LW'(inflight_q) + LW'(out_count_q);
        level         = (total > DEPTH_L) ? DEPTH_C : total[CW-1:0];
    end

    // Next-state for pointers, occupancy and the output buffer; flush wipes everything.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_fire);
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(rd_issue);
        mem_count_d = mem_count_q + CW'(wr_fire) - CW'(rd_issue);
        inflight_d  = rd_issue;
        out0_d      = out0_q;
        out1_d      = out1_q;
        out_count_d = out_count_q;
        if (pop) begin
            out0_d      = out1_q;
            out_count_d = out_count_q - 2'd1;
        end
        if (inflight_q) begin
            if (out_count_d == 2'd0) begin
                out0_d = sram_r0_rd;
            end else begin
                out1_d = sram_r0_rd;
            end
            out_count_d = out_count_d + 2'd1;
        end
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_count_d = '0;
            inflight_d  = 1'b0;
            out_count_d = 2'd0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            inflight_q  <= 1'b0;
            out_count_q <= 2'd0;
            out0_q      <= '0;
            out1_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            inflight_q  <= inflight_d;
            out_count_q <= out_count_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
        end
    end

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Testbench for liteeth_sram_fifo_ctrl: behavioural SRAM plus a queue-based FIFO reference.
module tb_liteeth_sram_fifo_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LW    = AW + 1;

    logic          clk = 1'b0;
    logic          rstN;
    logic          flushIn;
    logic          sinkValid;
    logic          sinkReady;
    logic [63:0]   sinkData;
    logic          sourceValid;
    logic          sourceReady;
    logic [63:0]   sourceData;
    logic [AW:0]   levelOut;
    logic          sramRw0Ce;
    logic          sramRw0We;
    logic [AW-1:0] sramRw0Addr;
    logic [63:0]   sramRw0Wd;
    logic          sramR0Ce;
    logic [AW-1:0] sramR0Addr;
    logic [63:0]   sramR0Rd;

    logic [63:0]   sramMem [DEPTH];
    logic [63:0]   q[$];
    int            passCount = 0;
    int            checkCount = 0;

    liteeth_sram_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rstN),
        .flush        (flushIn),
        .sink_valid   (sinkValid),
        .sink_ready   (sinkReady),
        .sink_data    (sinkData),
        .source_valid (sourceValid),
        .source_ready (sourceReady),
        .source_data  (sourceData),
        .level        (levelOut),
        .sram_rw0_ce  (sramRw0Ce),
        .sram_rw0_we  (sramRw0We),
        .sram_rw0_addr(sramRw0Addr),
        .sram_rw0_wd  (sramRw0Wd),
        .sram_r0_ce   (sramR0Ce),
        .sram_r0_addr (sramR0Addr),
        .sram_r0_rd   (sramR0Rd)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural 1rw1r SRAM macro with one-cycle read latency.
    always @(posedge clk) begin
        if (sramRw0Ce && sramRw0We) sramMem[sramRw0Addr] <= sramRw0Wd;
        if (sramR0Ce) sramR0Rd <= sramMem[sramR0Addr];
    end

    // Words held by an ideal FIFO, clipped the way the level output reports them.
    function automatic logic [AW:0] expLevel();
        return (q.size() > DEPTH) ? LW'(DEPTH) : LW'(q.size());
    endfunction

    // Drive one cycle of inputs at the falling edge and sample the handshake results.
    task automatic driveCycle(input logic sv, input logic [63:0] sd, input logic sr, input logic fl,
                              output logic fire, output logic pop, output logic [63:0] dout,
                              output logic [AW:0] lvl);
        @(negedge clk);
        sinkValid   = sv;
        sinkData    = sd;
        sourceReady = sr;
        flushIn     = fl;
        #1;
        fire = sv && sinkReady;
        pop  = sourceValid && sr;
        dout = sourceData;
        lvl  = levelOut;
    endtask

    task automatic test_reset();
        rstN = 1'b1; flushIn = 1'b0; sinkValid = 1'b1; sinkData = '0; sourceReady = 1'b0;
        #2 rstN = 1'b0;
        #1;
        checkCount++;
        if ({sinkReady, sramRw0Ce, sramR0Ce, sourceValid} !== 4'b0000) $display("[TB] FAIL reset_gating: got %b expected 0000", {sinkReady, sramRw0Ce, sramR0Ce, sourceValid});
        else passCount++;
        checkCount++;
        if (levelOut !== '0) $display("[TB] FAIL reset_level: got %0d expected 0", levelOut);
        else passCount++;
        repeat (2) @(negedge clk);
        sinkValid = 1'b0;
        rstN = 1'b1;
        #1;
        checkCount++;
        if (sinkReady !== 1'b1) $display("[TB] FAIL reset_release_ready: got %b expected 1", sinkReady);
        else passCount++;
    endtask

    task automatic test_latency();
        logic fire, pop; logic [63:0] dout, exp; logic [AW:0] lvl;
        int firstFire = -1, firstCe = -1, firstValid = -1, firstPop = -1, lastPop = -1, pops = 0, sent = 0;
        for (int c = 0; c < 20; c++) begin
            driveCycle(sent < 5, 64'(sent), 1'b1, 1'b0, fire, pop, dout, lvl);
            checkCount++;
            if (lvl !== expLevel()) $display("[TB] FAIL lat_level: got %0d expected %0d", lvl, expLevel());
            else passCount++;
            if (sramR0Ce && firstCe < 0) firstCe = c;
            if (sourceValid && firstValid < 0) firstValid = c;
            if (pop) begin
                checkCount++;
                if (q.size() == 0) $display("[TB] FAIL lat_spurious_pop: got %h expected none", dout);
                else begin
                    exp = q.pop_front();
                    if (dout !== exp) $display("[TB] FAIL lat_data: got %h expected %h", dout, exp);
                    else passCount++;
                end
                pops++;
                if (firstPop < 0) firstPop = c;
                lastPop = c;
            end
            if (fire) begin
                if (firstFire < 0) firstFire = c;
                q.push_back(64'(sent));
                sent++;
            end
        end
        checkCount++;
        if (firstCe !== firstFire + 1) $display("[TB] FAIL lat_read_issue: got cycle %0d expected %0d", firstCe, firstFire + 1);
        else passCount++;
        checkCount++;
        if (firstValid !== firstFire + 3) $display("[TB] FAIL lat_first_valid: got cycle %0d expected %0d", firstValid, firstFire + 3);
        else passCount++;
        checkCount++;
        if (pops !== 5 || lastPop - firstPop !== 4) $display("[TB] FAIL lat_consecutive: got %0d pops over %0d cycles expected 5 over 4", pops, lastPop - firstPop);
        else passCount++;
    endtask

    task automatic test_capacity();
        logic fire, pop; logic [63:0] dout, exp; logic [AW:0] lvl;
        int accepted = 0, pops = 0;
        for (int c = 0; c < 90; c++) begin
            driveCycle(1'b1, 64'h100 + 64'(accepted), 1'b0, 1'b0, fire, pop, dout, lvl);
            checkCount++;
            if (lvl !== expLevel()) $display("[TB] FAIL cap_level: got %0d expected %0d", lvl, expLevel());
            else passCount++;
            if (fire) begin
                q.push_back(64'h100 + 64'(accepted));
                accepted++;
            end
        end
        checkCount++;
        if (accepted !== DEPTH + 2) $display("[TB] FAIL cap_accepted: got %0d expected %0d", accepted, DEPTH + 2);
        else passCount++;
        checkCount++;
        if (sinkReady !== 1'b0 || lvl !== LW'(DEPTH)) $display("[TB] FAIL cap_full: got ready=%b level=%0d expected ready=0 level=%0d", sinkReady, lvl, DEPTH);
        else passCount++;
        checkCount++;
        if (sourceValid !== 1'b1 || dout !== 64'h100) $display("[TB] FAIL cap_head: got valid=%b data=%h expected valid=1 data=100", sourceValid, dout);
        else passCount++;
        for (int c = 0; c < 120 && q.size() > 0; c++) begin
            driveCycle(1'b0, '0, 1'b1, 1'b0, fire, pop, dout, lvl);
            checkCount++;
            if (lvl !== expLevel()) $display("[TB] FAIL cap_drain_level: got %0d expected %0d", lvl, expLevel());
            else passCount++;
            if (pop) begin
                exp = q.pop_front();
                pops++;
                checkCount++;
                if (dout !== exp) $display("[TB] FAIL cap_drain_data: got %h expected %h", dout, exp);
                else passCount++;
            end
        end
        checkCount++;
        if (pops !== DEPTH + 2) $display("[TB] FAIL cap_drain_count: got %0d expected %0d", pops, DEPTH + 2);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        logic fire, pop; logic [63:0] dout, exp; logic [AW:0] lvl;
        int sent = 0, pops = 0, firstFire = -1;
        for (int c = 0; c < 230 && pops < 200; c++) begin
            driveCycle(sent < 200, 64'h2000 + 64'(sent), 1'b1, 1'b0, fire, pop, dout, lvl);
            if (sent < 200) begin
                checkCount++;
                if (sinkReady !== 1'b1) $display("[TB] FAIL stream_sink_ready: got %b expected 1 at word %0d", sinkReady, sent);
                else passCount++;
            end
            if (firstFire >= 0 && c >= firstFire + 3) begin
                checkCount++;
                if (sourceValid !== 1'b1) $display("[TB] FAIL stream_source_valid: got %b expected 1 at cycle %0d", sourceValid, c);
                else passCount++;
            end
            if (pop) begin
                pops++;
                checkCount++;
                if (q.size() == 0) $display("[TB] FAIL stream_spurious_pop: got %h expected none", dout);
                else begin
                    exp = q.pop_front();
                    if (dout !== exp) $display("[TB] FAIL stream_data: got %h expected %h", dout, exp);
                    else passCount++;
                end
            end
            if (fire) begin
                if (firstFire < 0) firstFire = c;
                q.push_back(64'h2000 + 64'(sent));
                sent++;
            end
        end
        checkCount++;
        if (pops !== 200 || q.size() !== 0) $display("[TB] FAIL stream_count: got %0d popped expected 200", pops);
        else passCount++;
    endtask

    task automatic test_random();
        logic fire, pop, sv, sr, prevStall; logic [63:0] dout, exp, word, prevData; logic [AW:0] lvl;
        int sent = 0, pops = 0;
        prevStall = 1'b0; prevData = '0;
        for (int c = 0; c < 6000 && (sent < 500 || pops < 500); c++) begin
            sv   = (sent < 500) && ($urandom_range(0, 3) != 0);
            sr   = 1'($urandom_range(0, 1));
            word = {$urandom(), $urandom()};
            driveCycle(sv, word, sr, 1'b0, fire, pop, dout, lvl);
            checkCount++;
            if (lvl !== expLevel()) $display("[TB] FAIL rand_level: got %0d expected %0d", lvl, expLevel());
            else passCount++;
            if (prevStall) begin
                checkCount++;
                if (sourceValid !== 1'b1 || dout !== prevData) $display("[TB] FAIL rand_stable: got valid=%b data=%h expected valid=1 data=%h", sourceValid, dout, prevData);
                else passCount++;
            end
            prevStall = sourceValid && !sr;
            prevData  = dout;
            if (pop) begin
                pops++;
                checkCount++;
                if (q.size() == 0) $display("[TB] FAIL rand_spurious_pop: got %h expected none", dout);
                else begin
                    exp = q.pop_front();
                    if (dout !== exp) $display("[TB] FAIL rand_data: got %h expected %h", dout, exp);
                    else passCount++;
                end
            end
            if (fire) begin
                q.push_back(word);
                sent++;
            end
        end
        checkCount++;
        if (sent !== 500 || pops !== 500) $display("[TB] FAIL rand_count: got sent=%0d popped=%0d expected 500/500", sent, pops);
        else passCount++;
    endtask

    task automatic test_flush();
        logic fire, pop; logic [63:0] dout, exp; logic [AW:0] lvl;
        int pops = 0, sentAA = 0;
        for (int i = 0; i < 10; i++) begin
            driveCycle(1'b1, 64'hF00 + 64'(i), 1'b0, 1'b0, fire, pop, dout, lvl);
            if (fire) q.push_back(64'hF00 + 64'(i));
        end
        repeat (3) driveCycle(1'b0, '0, 1'b0, 1'b0, fire, pop, dout, lvl);
        driveCycle(1'b0, '0, 1'b1, 1'b0, fire, pop, dout, lvl);
        exp = (q.size() > 0) ? q.pop_front() : 64'hDEAD;
        checkCount++;
        if (pop !== 1'b1 || dout !== exp || sramR0Ce !== 1'b1) $display("[TB] FAIL flush_prepop: got pop=%b data=%h ce=%b expected pop=1 data=%h ce=1", pop, dout, sramR0Ce, exp);
        else passCount++;
        driveCycle(1'b1, 64'hBB, 1'b0, 1'b1, fire, pop, dout, lvl);
        checkCount++;
        if ({sinkReady, sramRw0Ce, sramR0Ce} !== 3'b000) $display("[TB] FAIL flush_cycle_gating: got %b expected 000", {sinkReady, sramRw0Ce, sramR0Ce});
        else passCount++;
        q.delete();
        driveCycle(1'b0, '0, 1'b0, 1'b0, fire, pop, dout, lvl);
        checkCount++;
        if (sourceValid !== 1'b0 || lvl !== '0) $display("[TB] FAIL flush_cleared: got valid=%b level=%0d expected valid=0 level=0", sourceValid, lvl);
        else passCount++;
        for (int c = 0; c < 12; c++) begin
            driveCycle(sentAA == 0, 64'hAA, 1'b1, 1'b0, fire, pop, dout, lvl);
            if (pop) begin
                pops++;
                checkCount++;
                if (dout !== 64'hAA) $display("[TB] FAIL flush_first_word: got %h expected aa", dout);
                else passCount++;
            end
            if (fire) sentAA++;
        end
        checkCount++;
        if (pops !== 1) $display("[TB] FAIL flush_pop_count: got %0d expected 1", pops);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        logic fire, pop; logic [63:0] dout, exp; logic [AW:0] lvl;
        int sent = 0, pops = 0;
        for (int c = 0; c < 20; c++) begin
            driveCycle(1'b1, 64'h5000 + 64'(c), 1'b1, 1'b0, fire, pop, dout, lvl);
            if (pop && q.size() > 0) begin
                exp = q.pop_front();
                checkCount++;
                if (dout !== exp) $display("[TB] FAIL rmid_pre_data: got %h expected %h", dout, exp);
                else passCount++;
            end
            if (fire) q.push_back(64'h5000 + 64'(c));
        end
        @(negedge clk);
        sinkValid = 1'b1;
        rstN = 1'b0;
        #1;
        checkCount++;
        if ({sinkReady, sramRw0Ce, sramR0Ce, sourceValid} !== 4'b0000) $display("[TB] FAIL rmid_gating: got %b expected 0000", {sinkReady, sramRw0Ce, sramR0Ce, sourceValid});
        else passCount++;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        sinkValid = 1'b0;
        rstN = 1'b1;
        #1;
        checkCount++;
        if (sinkReady !== 1'b1 || levelOut !== '0) $display("[TB] FAIL rmid_release: got ready=%b level=%0d expected ready=1 level=0", sinkReady, levelOut);
        else passCount++;
        for (int c = 0; c < 25; c++) begin
            driveCycle(sent < 8, 64'h6000 + 64'(sent), 1'b1, 1'b0, fire, pop, dout, lvl);
            if (pop) begin
                pops++;
                checkCount++;
                if (q.size() == 0) $display("[TB] FAIL rmid_spurious_pop: got %h expected none", dout);
                else begin
                    exp = q.pop_front();
                    if (dout !== exp) $display("[TB] FAIL rmid_data: got %h expected %h", dout, exp);
                    else passCount++;
                end
            end
            if (fire) begin
                q.push_back(64'h6000 + 64'(sent));
                sent++;
            end
        end
        checkCount++;
        if (pops !== 8) $display("[TB] FAIL rmid_count: got %0d expected 8", pops);
        else passCount++;
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_latency();
        test_capacity();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
